// File: rtl/bus_reg_file.sv
// bus_reg_file: 16 x 32-bit general-purpose registers fed from the shared bus,
// with instruction-field index decode, read select encode and C sign extension.
module bus_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clock,
  input  logic                           clear,
  input  logic [DATA_WIDTH-1:0]          BusMuxOut,
  input  logic [31:0]                    IR,
  input  logic                           Gra,
  input  logic                           Grb,
  input  logic                           Grc,
  input  logic                           Rin,
  input  logic                           Rout,
  input  logic                           BAout,
  output logic [DATA_WIDTH*NUM_REGS-1:0] RegOut_flat,
  output logic [DATA_WIDTH-1:0]          R0_gated,
  output logic [DATA_WIDTH-1:0]          C_sign_extended,
  output logic [4:0]                     Rout_select,
  output logic                           Rout_valid,
  output logic                           wr_conflict
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [3:0]            sel;
  logic                  anyGr;
  logic                  multiGr;
  logic                  readReq;

  always_comb begin
    sel = 4'd0;
    if (Gra)      sel = IR[26:23];
    else if (Grb) sel = IR[22:19];
    else if (Grc) sel = IR[18:15];
  end

  assign anyGr   = Gra | Grb | Grc;
  assign multiGr = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
  assign readReq = (Rout | BAout) & anyGr;

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (Rin && anyGr)
        regs[sel] <= BusMuxOut;
      if (multiGr)
        wr_conflict <= 1'b1;
    end
  end

  always_comb begin
    RegOut_flat = '0;
    for (int i = 0; i < NUM_REGS; i++)
      RegOut_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  // Base-address reads treat R0 as constant zero
  assign R0_gated = BAout ? '0 : regs[0];

  assign C_sign_extended =
    {{(DATA_WIDTH-19){IR[18]}}, IR[18:0]};

  assign Rout_valid  = readReq;
  assign Rout_select = readReq ? {1'b0, sel} : 5'd0;

endmodule
